parking_gate_arbiter: RTL and testbench

- Arbitrates one shared barrier gate between the entry lane and the exit lane of the normal parking area.
- Sequences each gate cycle: grant, open, wait for the car to pass, close.
- Emits exactly one count pulse per completed passage, to drive the normal-space counter's entry and exit inputs.
- Refuses entry when no space is available. Alternates service fairly when both lanes are waiting.

---
 rtl/parking_gate_arbiter_pkg.sv | 28 ++
 rtl/parking_gate_arbiter_if.sv | 27 ++
 rtl/parking_gate_arbiter_timer.sv | 34 +++
 rtl/parking_gate_arbiter.sv | 140 ++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_gate_arbiter_pkg.sv
// parking_pkg: shared types and constants for the parking gate arbiter.
//   gate_state_t           - arbiter FSM states (IDLE, OPEN, CLOSE)
//   DIR_ENTRY / DIR_EXIT   - lane encodings for dir / last_served
//   DEF_*_CYCLES           - default gate timing
//   timer_width()          - width of the shared gate timer
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSE
  } gate_state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 32;
  localparam int unsigned DEF_CLOSE_CYCLES   = 4;

  // One spare bit over the larger limit so the counter can never wrap.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// parking_gate_arbiter_if: lane/loop inputs and gate/counter outputs.
//   master - environment side: drives requests, loop and space levels
//   slave  - arbiter side: drives barrier, count pulses and status
interface parking_gate_arbiter_if;

  logic entry_req;
  logic exit_req;
  logic space_avail;
  logic car_passed;
  logic gate_open;
  logic entry_pulse;
  logic exit_pulse;
  logic busy;
  logic deny;
  logic timeout_err;

  modport master (
    output entry_req, exit_req, space_avail, car_passed,
    input  gate_open, entry_pulse, exit_pulse, busy, deny, timeout_err
  );

  modport slave (
    input  entry_req, exit_req, space_avail, car_passed,
    output gate_open, entry_pulse, exit_pulse, busy, deny, timeout_err
  );

endinterface

// File: rtl/parking_gate_arbiter_timer.sv
// park_gate_timer: up-counter shared by the OPEN and CLOSE phases.
//   clk, reset - clock, asynchronous active-low reset
//   clear      - synchronous clear to zero (wins over enable)
//   enable     - count up by one
//   limit      - runtime terminal value
//   tc         - count == limit
module park_gate_timer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    tc = (count == limit);
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between the entry and exit
// lanes of the normal parking area.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - slave side of parking_gate_arbiter_if:
//            in : entry_req, exit_req, space_avail, car_passed
//            out: gate_open, entry_pulse, exit_pulse, busy, deny, timeout_err
// A gate cycle is grant -> OPEN (until car_passed or timeout) -> CLOSE
// (fixed barrier travel) -> IDLE. Contended grants alternate lanes.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CLOSE_CYCLES   = DEF_CLOSE_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int unsigned TW = timer_width(TIMEOUT_CYCLES, CLOSE_CYCLES);
  localparam logic [TW-1:0] OPEN_LIMIT  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CLOSE_LIMIT = TW'(CLOSE_CYCLES - 1);

  gate_state_t state_q, state_d;
  logic        dir_q, dir_d;
  logic        last_q, last_d;

  logic          timer_clear;
  logic          timer_en;
  logic [TW-1:0] timer_limit;
  logic          timer_tc;

  logic entry_ok;
  logic exit_ok;
  logic gate_open_d;
  logic entry_pulse_d;
  logic exit_pulse_d;
  logic busy_d;
  logic deny_d;
  logic timeout_d;

  park_gate_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (timer_limit),
    .tc     (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    last_d        = last_q;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;
    timer_limit   = (state_q == OPEN) ? OPEN_LIMIT : CLOSE_LIMIT;
    entry_pulse_d = 1'b0;
    exit_pulse_d  = 1'b0;
    timeout_d     = 1'b0;

    entry_ok = bus.entry_req & bus.space_avail;
    exit_ok  = bus.exit_req;
    deny_d   = (state_q == IDLE) & bus.entry_req & ~bus.space_avail;

    case (state_q)
      IDLE: begin
        if (entry_ok || exit_ok) begin
          // Under contention serve the lane that did not go last.
          if (entry_ok && exit_ok) begin
            dir_d = ~last_q;
          end else if (entry_ok) begin
            dir_d = DIR_ENTRY;
          end else begin
            dir_d = DIR_EXIT;
          end
          last_d      = dir_d;
          timer_clear = 1'b1;
          state_d     = OPEN;
        end
      end
      OPEN: begin
        // car_passed is checked first so it wins over a coincident timeout.
        if (bus.car_passed) begin
          state_d       = CLOSE;
          timer_clear   = 1'b1;
          entry_pulse_d = (dir_q == DIR_ENTRY);
          exit_pulse_d  = (dir_q == DIR_EXIT);
        end else if (timer_tc) begin
          state_d     = CLOSE;
          timer_clear = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      CLOSE: begin
        if (timer_tc) begin
          state_d = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gate_open_d = (state_d == OPEN);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      dir_q           <= DIR_ENTRY;
      last_q          <= DIR_EXIT;
      bus.gate_open   <= 1'b0;
      bus.entry_pulse <= 1'b0;
      bus.exit_pulse  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.deny        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      last_q          <= last_d;
      bus.gate_open   <= gate_open_d;
      bus.entry_pulse <= entry_pulse_d;
      bus.exit_pulse  <= exit_pulse_d;
      bus.busy        <= busy_d;
      bus.deny        <= deny_d;
      bus.timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the gate arbiter.
module tb_parking_gate_arbiter;

  localparam int unsigned TO = 32;
  localparam int unsigned CL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_gate_arbiter_if bus ();

  parking_gate_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .CLOSE_CYCLES   (CL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Behavioural model: gate open flag, age within OPEN, remaining close
  // cycles, lane bookkeeping, and expected registered outputs.
  bit m_open;
  int m_age;
  int m_close_left;
  bit m_last_exit;
  bit m_dir_exit;
  bit e_gate, e_entry, e_exit, e_busy, e_deny, e_to;

  bit pulse_q[$];
  int n_entry_seen;
  int n_exit_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_age = 0; m_close_left = 0;
    m_last_exit = 1; m_dir_exit = 0;
    e_gate = 0; e_entry = 0; e_exit = 0; e_busy = 0; e_deny = 0; e_to = 0;
  endtask

  task automatic model_step();
    bit idle;
    bit eok;
    bit xok;
    idle = !m_open && (m_close_left == 0);
    eok  = bus.entry_req && bus.space_avail;
    xok  = bus.exit_req;
    e_deny = idle && bus.entry_req && !bus.space_avail;
    e_entry = 0; e_exit = 0; e_to = 0;
    if (idle) begin
      if (eok || xok) begin
        m_dir_exit  = (eok && xok) ? !m_last_exit : xok;
        m_last_exit = m_dir_exit;
        m_open = 1;
        m_age  = 0;
      end
    end else if (m_open) begin
      if (bus.car_passed) begin
        if (m_dir_exit) e_exit = 1; else e_entry = 1;
        m_open = 0;
        m_close_left = CL;
      end else if (m_age == TO - 1) begin
        e_to = 1;
        m_open = 0;
        m_close_left = CL;
      end else begin
        m_age++;
      end
    end else begin
      m_close_left--;
    end
    e_gate = m_open;
    e_busy = m_open || (m_close_left > 0);
  endtask

  task automatic compare_all();
    check_eq("gate_open", bus.gate_open, e_gate);
    check_eq("entry_pulse", bus.entry_pulse, e_entry);
    check_eq("exit_pulse", bus.exit_pulse, e_exit);
    check_eq("busy", bus.busy, e_busy);
    check_eq("deny", bus.deny, e_deny);
    check_eq("timeout_err", bus.timeout_err, e_to);
    if (bus.entry_pulse === 1'b1) begin pulse_q.push_back(1'b0); n_entry_seen++; end
    if (bus.exit_pulse === 1'b1)  begin pulse_q.push_back(1'b1); n_exit_seen++; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit e, input bit x, input bit s, input bit c);
    bus.entry_req = e; bus.exit_req = x; bus.space_avail = s; bus.car_passed = c;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    drive(0, 0, 1, 0);
    while (bus.busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check_eq("wait_idle", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] gmask;
    logic [10:0] emask;
    logic        busy10;
    int          cnt_gate, cnt_deny, cnt_pulse, k, ex0;

    reset = 1'b0;
    drive(0, 0, 1, 0);
    model_reset();
    repeat (3) tick();
    check_eq("reset_gate", bus.gate_open, 0);
    check_eq("reset_busy", bus.busy, 0);
    #2 reset = 1'b1;

    // Single entry: car_passed during cycle 5.
    gmask = '0; emask = '0; busy10 = 1'b1;
    drive(1, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      gmask[i] = bus.gate_open;
      emask[i] = bus.entry_pulse;
      if (i == 10) busy10 = bus.busy;
      bus.entry_req  = 1'b0;
      bus.car_passed = (i == 5);
    end
    check_eq("single_gate_mask", gmask, 11'b000_0011_1110);
    check_eq("single_pulse_mask", emask, 11'b000_0100_0000);
    check_eq("single_busy_c10", busy10, 0);

    // Full lot: entry refused while exit still honoured.
    wait_idle();
    cnt_gate = 0; cnt_deny = 0; cnt_pulse = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_gate  += int'(bus.gate_open);
      cnt_deny  += int'(bus.deny);
      cnt_pulse += int'(bus.entry_pulse) + int'(bus.exit_pulse);
    end
    check_eq("full_gate_cnt", cnt_gate, 0);
    check_eq("full_deny_cnt", cnt_deny, 20);
    check_eq("full_pulse_cnt", cnt_pulse, 0);
    bus.exit_req = 1'b1;
    tick();
    check_eq("full_exit_grant", bus.gate_open, 1);
    drive(0, 0, 0, 1);
    tick();
    wait_idle();

    // Contention: grants alternate starting with entry.
    pulse_q.delete();
    drive(1, 1, 1, 0);
    for (int i = 0; i < 60 && pulse_q.size() < 3; i++) begin
      tick();
      bus.car_passed = m_open;
    end
    drive(0, 0, 1, 0);
    check_eq("cont_npulses", pulse_q.size(), 3);
    if (pulse_q.size() >= 3) begin
      check_eq("cont_order0", pulse_q[0], 0);
      check_eq("cont_order1", pulse_q[1], 1);
      check_eq("cont_order2", pulse_q[2], 0);
    end
    wait_idle();

    // Timeout: 32 cycles from gate rise to timeout_err.
    ex0 = n_entry_seen;
    drive(1, 0, 1, 0);
    tick();
    check_eq("to_gate_rise", bus.gate_open, 1);
    bus.entry_req = 1'b0;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin
        k = i;
        break;
      end
    end
    check_eq("to_latency", k, 32);
    check_eq("to_gate_closed", bus.gate_open, 0);
    wait_idle();
    check_eq("to_no_pulse", n_entry_seen - ex0, 0);

    // Long car on exit: one pulse only.
    ex0 = n_exit_seen;
    drive(0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 1);
    repeat (10) tick();
    wait_idle();
    check_eq("long_car_pulses", n_exit_seen - ex0, 1);

    // Async reset mid-OPEN after an entry grant; entry must win next contention.
    drive(1, 0, 1, 0);
    tick();
    bus.entry_req = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check_eq("arst_gate", bus.gate_open, 0);
    check_eq("arst_busy", bus.busy, 0);
    model_reset();
    tick();
    tick();
    #2 reset = 1'b1;
    pulse_q.delete();
    drive(1, 1, 1, 0);
    for (int i = 0; i < 20 && pulse_q.size() < 1; i++) begin
      tick();
      bus.car_passed = m_open;
    end
    check_eq("arst_first_pulses", pulse_q.size(), 1);
    if (pulse_q.size() >= 1) check_eq("arst_first_entry", pulse_q[0], 0);
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0);
      tick();
      check_eq("pulse_exclusive", bus.entry_pulse & bus.exit_pulse, 0);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
